// File: rtl/vec_pkg.sv
// Shared definitions for the vector lane sequencer: ALU opcodes, FSM states, idle ALU function.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vec_pkg;

  // Scalar ALU function encoding
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;

  // Function presented to the ALU whenever no lane is being issued
  localparam logic [2:0] ALU_F_IDLE = OP_MOV;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/vector_lane_mux.sv
// Selects one N-bit element (lane) out of a packed LANES*N vector.
// Latency: combinational.
// Backpressure: none.
module vector_lane_mux
  import vec_pkg::*;
#(
  parameter int N     = 8,
  parameter int LANES = 4,
  parameter int LW    = $clog2(LANES)
) (
  input  logic [LANES*N-1:0] vec,
  input  logic [LW-1:0]      lane,
  output logic [N-1:0]       elem
);

  // Compare-and-select per lane; out-of-range lane numbers yield zero
  always_comb begin
    elem = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane == LW'(i)) elem = vec[i*N +: N];
    end
  end

endmodule

// File: rtl/vector_lane_sequencer.sv
// Serialises one vector instruction into LANES scalar ALU operations, gathering results into a vector.
// Latency: accept at edge k, lane i written at edge k+1+i, out_valid from edge k+LANES; one instr per LANES+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Option macro: VLS_DIV0_GUARD_EN.
module vector_lane_sequencer
  import vec_pkg::*;
#(
  parameter int N     = 8,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [LANES*N-1:0] in_va,
  input  logic [LANES*N-1:0] in_vb,
  output logic [N-1:0]       alu_a,
  output logic [N-1:0]       alu_b,
  output logic [2:0]         alu_f,
  input  logic [N-1:0]       alu_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_vr,
  output logic               out_div0
);

  localparam int             LW        = $clog2(LANES);
  localparam logic [LW-1:0]  LAST_LANE = LW'(LANES - 1);

  seq_state_t         state_q, state_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic [2:0]         op_q, op_d;
  logic [LANES*N-1:0] va_q, va_d;
  logic [LANES*N-1:0] vb_q, vb_d;
  logic [LANES*N-1:0] vr_q, vr_d;
  logic [N-1:0]       lane_a, lane_b, wr_dat;
  logic               div0_hit;
`ifdef VLS_DIV0_GUARD_EN
  logic               div0_q, div0_d;
`endif

  vector_lane_mux #(.N(N), .LANES(LANES), .LW(LW)) u_mux_a (
    .vec  (va_q),
    .lane (lane_q),
    .elem (lane_a)
  );

  vector_lane_mux #(.N(N), .LANES(LANES), .LW(LW)) u_mux_b (
    .vec  (vb_q),
    .lane (lane_q),
    .elem (lane_b)
  );

  // Lane write data: ALU result, replaced by all-ones on a guarded divide by zero
  always_comb begin
    wr_dat   = alu_result;
    div0_hit = 1'b0;
`ifdef VLS_DIV0_GUARD_EN
    div0_hit = (op_q == OP_DIV) && (lane_b == '0);
    if (div0_hit) wr_dat = '1;
`endif
  end

  // Next-state logic: accept in IDLE, walk the lanes in ISSUE, wait for downstream in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_ISSUE;
      ST_ISSUE: if (lane_q == LAST_LANE) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, write one result lane per ISSUE cycle
  always_comb begin
    lane_d = lane_q;
    op_d   = op_q;
    va_d   = va_q;
    vb_d   = vb_q;
    vr_d   = vr_q;
`ifdef VLS_DIV0_GUARD_EN
    div0_d = div0_q;
`endif
    if (state_q == ST_IDLE && in_valid) begin
      op_d   = in_op;
      va_d   = in_va;
      vb_d   = in_vb;
      lane_d = '0;
`ifdef VLS_DIV0_GUARD_EN
      div0_d = 1'b0;
`endif
    end else if (state_q == ST_ISSUE) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_q == LW'(i)) vr_d[i*N +: N] = wr_dat;
      end
      lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + LW'(1);
`ifdef VLS_DIV0_GUARD_EN
      div0_d = div0_q | div0_hit;
`endif
    end
  end

  // Outputs decoded from state and registers only
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !rst;
    out_valid = (state_q == ST_DONE);
    out_vr    = vr_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_f     = ALU_F_IDLE;
    if (state_q == ST_ISSUE) begin
      alu_a = lane_a;
      alu_b = lane_b;
      alu_f = op_q;
    end
`ifdef VLS_DIV0_GUARD_EN
    out_div0 = div0_q;
`else
    out_div0 = 1'b0;
`endif
  end

  // State registers with synchronous reset that drops any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      op_q    <= '0;
      va_q    <= '0;
      vb_q    <= '0;
      vr_q    <= '0;
`ifdef VLS_DIV0_GUARD_EN
      div0_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      op_q    <= op_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      vr_q    <= vr_d;
`ifdef VLS_DIV0_GUARD_EN
      div0_q  <= div0_d;
`endif
    end
  end

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Self-checking bench for vector_lane_sequencer with a behavioural scalar ALU beside it.
// Latency: n/a.
// Backpressure: exercised via directed out_ready / in_valid patterns. Honours VLS_DIV0_GUARD_EN.
module tb_vector_lane_sequencer;

  localparam int N = 8;
  localparam int LANES = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_op;
  logic [LANES*N-1:0] in_va, in_vb;
  logic [N-1:0]       alu_a, alu_b, alu_result;
  logic [2:0]         alu_f;
  logic               out_valid, out_ready;
  logic [LANES*N-1:0] out_vr;
  logic               out_div0;

  int checks = 0;
  int errors = 0;

  vector_lane_sequencer #(.N(N), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_va      (in_va),
    .in_vb      (in_vb),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vr     (out_vr),
    .out_div0   (out_div0)
  );

  always #5 clk = ~clk;

  // Behavioural scalar ALU (divide by zero yields 0, cmp yields a<b)
  function automatic logic [N-1:0] alu_fn(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    case (f)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a;
      3'b011:  return a * b;
      3'b100:  return (b == 0) ? '0 : a / b;
      3'b101:  return (a < b) ? 8'd1 : 8'd0;
      default: return '0;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_f, alu_a, alu_b);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // After an accept, c counts edges elapsed; lanes below c show new results,
  // the ALU sees lane c while c<LANES, and the vector is valid once c>=LANES.
  bit         m_ok = 0;
  bit         m_busy = 0;
  int         m_c = 0;
  logic [2:0] m_op;
  logic [N-1:0] m_va[LANES], m_vb[LANES], m_new[LANES], m_vis[LANES];
  bit         m_g[LANES];
  bit         m_div0v = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1; m_busy = 0; m_c = 0; m_div0v = 0;
      for (int j = 0; j < LANES; j++) m_vis[j] = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1; m_c = 0; m_op = in_op;
        for (int j = 0; j < LANES; j++) begin
          m_va[j]  = in_va[j*N +: N];
          m_vb[j]  = in_vb[j*N +: N];
          m_new[j] = alu_fn(in_op, m_va[j], m_vb[j]);
          m_g[j]   = 0;
`ifdef VLS_DIV0_GUARD_EN
          if (in_op == 3'b100 && m_vb[j] == 0) begin
            m_new[j] = '1;
            m_g[j]   = 1;
          end
`endif
        end
      end
    end else if (m_c >= LANES && out_ready) begin
      m_busy = 0;
      m_div0v = 0;
      for (int j = 0; j < LANES; j++) begin
        m_vis[j] = m_new[j];
        if (m_g[j]) m_div0v = 1;
      end
    end else begin
      m_c++;
    end
  end

  // Compare DUT outputs against the model on every falling edge
  always @(negedge clk) begin
    if (m_ok) begin
      logic [LANES*N-1:0] e_vr;
      logic e_div0, e_vld, e_rdy;
      logic [N-1:0] e_a, e_b;
      logic [2:0] e_f;
      e_div0 = m_busy ? 1'b0 : m_div0v;
      for (int j = 0; j < LANES; j++) begin
        e_vr[j*N +: N] = (m_busy && j < m_c) ? m_new[j] : (m_busy ? m_vis[j] : m_vis[j]);
        if (m_busy && j < m_c && m_g[j]) e_div0 = 1'b1;
      end
      e_vld = m_busy && (m_c >= LANES);
      e_rdy = !m_busy && !rst;
      e_a = '0; e_b = '0; e_f = 3'b010;
      if (m_busy && m_c < LANES) begin
        e_a = m_va[m_c]; e_b = m_vb[m_c]; e_f = m_op;
      end
      check("m_out_vr", 64'(out_vr), 64'(e_vr));
      check("m_out_valid", 64'(out_valid), 64'(e_vld));
      check("m_in_ready", 64'(in_ready), 64'(e_rdy));
      check("m_out_div0", 64'(out_div0), 64'(e_div0));
      check("m_alu_a", 64'(alu_a), 64'(e_a));
      check("m_alu_b", 64'(alu_b), 64'(e_b));
      check("m_alu_f", 64'(alu_f), 64'(e_f));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present an instruction and hold it until accepted; returns #1 after the accept edge
  task automatic send(input logic [2:0] op, input logic [LANES*N-1:0] va, input logic [LANES*N-1:0] vb);
    int n = 0;
    in_op = op; in_va = va; in_vb = vb; in_valid = 1'b1;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) check("send_timeout", 64'(0), 64'(1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    if (!out_valid) check("done_timeout", 64'(0), 64'(1));
  endtask

  localparam logic [31:0] ADD_VA = 32'h04030201, ADD_VB = 32'h0A141E28, ADD_VR = 32'h0E172029;
  localparam logic [31:0] MUL_VA = 32'h00FF0210, MUL_VB = 32'h09020310, MUL_VR = 32'h00FE0600;
  localparam logic [31:0] DIV_VA = 32'hC8093264, DIV_VB = 32'hC9000507;

  initial begin
    logic [7:0] exp_a[4];
    logic [7:0] exp_b[4];
    exp_a = '{8'd1, 8'd2, 8'd3, 8'd4};
    exp_b = '{8'd40, 8'd30, 8'd20, 8'd10};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_va = '0; in_vb = '0;
    repeat (3) step();
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_vr", 64'(out_vr), 64'(0));
    check("rst_alu_f", 64'(alu_f), 64'(3'b010));
    rst = 1'b0; #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Add: ALU drive order and latency
    send(3'b000, ADD_VA, ADD_VB);
    for (int k = 0; k < LANES; k++) begin
      check("drv_alu_a", 64'(alu_a), 64'(exp_a[k]));
      check("drv_alu_b", 64'(alu_b), 64'(exp_b[k]));
      check("drv_alu_f", 64'(alu_f), 64'(3'b000));
      check("early_valid", 64'(out_valid), 64'(0));
      step();
    end
    check("add_latency_valid", 64'(out_valid), 64'(1));
    check("add_vr", 64'(out_vr), 64'(ADD_VR));
    check("done_alu_f", 64'(alu_f), 64'(3'b010));
    step();
    check("idle_alu_a", 64'(alu_a), 64'(0));
    check("idle_out_valid", 64'(out_valid), 64'(0));
    check("idle_vr_held", 64'(out_vr), 64'(ADD_VR));

    // Mul wrap
    send(3'b011, MUL_VA, MUL_VB);
    wait_done();
    check("mul_vr", 64'(out_vr), 64'(MUL_VR));
    step();

    // Backpressure in DONE with a new instruction waiting
    out_ready = 1'b0;
    send(3'b000, ADD_VA, ADD_VB);
    wait_done();
    in_op = 3'b011; in_va = MUL_VA; in_vb = MUL_VB; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid", 64'(out_valid), 64'(1));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_vr", 64'(out_vr), 64'(ADD_VR));
    end
    out_ready = 1'b1;
    step();
    check("bp_release_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    wait_done();
    check("bp_next_vr", 64'(out_vr), 64'(MUL_VR));
    step();

    // Divide, including a zero divisor in lane 2
    send(3'b100, DIV_VA, DIV_VB);
    wait_done();
`ifdef VLS_DIV0_GUARD_EN
    check("div_vr", 64'(out_vr), 64'(32'h00FF0A0E));
    check("div_flag", 64'(out_div0), 64'(1));
`else
    check("div_vr", 64'(out_vr), 64'(32'h00000A0E));
    check("div_flag", 64'(out_div0), 64'(0));
`endif
    step();

    // Reset after lane 1 has been written
    send(3'b011, MUL_VA, MUL_VB);
    step();
    step();
    rst = 1'b1; #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    step();
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_vr", 64'(out_vr), 64'(0));
    check("mid_rst_div0", 64'(out_div0), 64'(0));
    check("mid_rst_alu_f", 64'(alu_f), 64'(3'b010));
    rst = 1'b0; #1;
    check("mid_rst_ready_after", 64'(in_ready), 64'(1));
    send(3'b000, ADD_VA, ADD_VB);
    wait_done();
    check("after_rst_add_vr", 64'(out_vr), 64'(ADD_VR));
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
